// File: rtl/mcc_pkg.sv
// Shared types for the multicycle LEGv8 controller: state encoding, opcode patterns, mux/ALU encodings.
// Pure declarations; no latency or backpressure.
package mcc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        WB_MEM   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        WB_R     = 4'd7,
        BRANCH_Z = 4'd8,
        JUMP     = 4'd9,
        HALT     = 4'd10
    } state_t;

    localparam logic [10:0] LDUR    = 11'b11111000010;
    localparam logic [10:0] STUR    = 11'b11111000000;
    localparam logic [10:0] ADD     = 11'b10001011000;
    localparam logic [10:0] SUB     = 11'b11001011000;
    localparam logic [10:0] AND     = 11'b10001010000;
    localparam logic [10:0] ORR     = 11'b10101010000;
    localparam logic [7:0]  CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  B_PFX   = 6'b000101;

    localparam logic [1:0] ALUB_BUSB    = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

endpackage

// File: rtl/mcc_opdecode.sv
// Combinational LEGv8 opcode classifier; zero latency, no backpressure.
// Exactly one class output (or illegal) is high for any opcode.
module mcc_opdecode
    import mcc_pkg::*;
(
    input  logic [10:0] i_opcode,
    output logic        o_is_mem,
    output logic        o_is_load,
    output logic        o_is_rtype,
    output logic        o_is_cbz,
    output logic        o_is_b,
    output logic        o_illegal
);

    assign o_is_load  = (i_opcode == LDUR);
    assign o_is_mem   = (i_opcode == LDUR) || (i_opcode == STUR);
    assign o_is_rtype = (i_opcode == ADD) || (i_opcode == SUB) ||
                        (i_opcode == AND) || (i_opcode == ORR);
    assign o_is_cbz   = (i_opcode[10:3] == CBZ_PFX);
    assign o_is_b     = (i_opcode[10:5] == B_PFX);
    assign o_illegal  = !(o_is_mem || o_is_rtype || o_is_cbz || o_is_b);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: 3-5 cycles per instruction plus memory wait; stalls on mem_ready, faults after MEM_TIMEOUT.
// Optional performance counters enabled by defining MCC_PERF_COUNTERS_EN.
module multicycle_control
    import mcc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [10:0] opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        Reg2Loc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        fault,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t            r_state;
    logic              r_fault;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_next;
    logic              w_waiting;
    logic              w_timeout;
    logic              w_is_mem, w_is_load, w_is_rtype, w_is_cbz, w_is_b, w_illegal;

    mcc_opdecode u_opdecode (
        .i_opcode   (opcode),
        .o_is_mem   (w_is_mem),
        .o_is_load  (w_is_load),
        .o_is_rtype (w_is_rtype),
        .o_is_cbz   (w_is_cbz),
        .o_is_b     (w_is_b),
        .o_illegal  (w_illegal)
    );

    assign w_waiting = (r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR);
    assign w_to_next = (r_to_cnt >= TO_LIMIT) ? r_to_cnt : r_to_cnt + 1'b1;
    // A ready arriving on the limit cycle still completes the access.
    assign w_timeout = !mem_ready && (w_to_next == TO_LIMIT);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state  <= FETCH;
            r_fault  <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            // Non-wait states hold the counter at zero so every wait starts fresh.
            if (w_waiting && !mem_ready) r_to_cnt <= w_to_next;
            else                         r_to_cnt <= '0;

            case (r_state)
                FETCH: begin
                    if (mem_ready)      r_state <= DECODE;
                    else if (w_timeout) begin r_state <= HALT; r_fault <= 1'b1; end
                end
                DECODE: begin
                    if (w_illegal)       begin r_state <= HALT; r_fault <= 1'b1; end
                    else if (w_is_mem)   r_state <= MEM_ADDR;
                    else if (w_is_rtype) r_state <= EXEC_R;
                    else if (w_is_cbz)   r_state <= BRANCH_Z;
                    else if (w_is_b)     r_state <= JUMP;
                end
                MEM_ADDR: r_state <= w_is_load ? MEM_RD : MEM_WR;
                MEM_RD: begin
                    if (mem_ready)      r_state <= WB_MEM;
                    else if (w_timeout) begin r_state <= HALT; r_fault <= 1'b1; end
                end
                WB_MEM: r_state <= FETCH;
                MEM_WR: begin
                    if (mem_ready)      r_state <= FETCH;
                    else if (w_timeout) begin r_state <= HALT; r_fault <= 1'b1; end
                end
                EXEC_R:   r_state <= WB_R;
                WB_R:     r_state <= FETCH;
                BRANCH_Z: r_state <= FETCH;
                JUMP:     r_state <= FETCH;
                HALT:     r_state <= HALT;
                default:  begin r_state <= HALT; r_fault <= 1'b1; end
            endcase
        end
    end

    // Strobes are forced low while reset is held, even though the state already reads FETCH.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        Reg2Loc     = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUB_BUSB;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        if (Reset_L) begin
            case (r_state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = ALUB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB = ALUB_IMM_SH2;
                    Reg2Loc = w_is_cbz || (w_is_mem && !w_is_load);
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ALUB_IMM;
                end
                MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                WB_MEM: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    Reg2Loc  = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_RTYPE;
                end
                WB_R: RegWrite = 1'b1;
                BRANCH_Z: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_PASSB;
                    Reg2Loc     = 1'b1;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_ALUOUT;
                end
                default: ;
            endcase
        end
    end

    assign state = r_state;
    assign fault = r_fault;

`ifdef MCC_PERF_COUNTERS_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;
    logic        w_retire;

    assign w_retire = (r_state == WB_MEM) || (r_state == WB_R) || (r_state == BRANCH_Z) ||
                      (r_state == JUMP) || ((r_state == MEM_WR) && mem_ready);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != HALT) r_cycle_cnt   <= r_cycle_cnt + 32'd1;
            if (w_retire)        r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-instruction expected state traces and per-state strobe tables.
module tb_multicycle_control;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_RD = 3, ST_WB_MEM = 4;
    localparam int ST_MEM_WR = 5, ST_EXEC_R = 6, ST_WB_R = 7, ST_BRANCH_Z = 8, ST_JUMP = 9, ST_HALT = 10;
    localparam int TIMEOUT = 15;
    localparam int C_RTYPE = 0, C_LDUR = 1, C_STUR = 2, C_CBZ = 3, C_B = 4;
`ifdef MCC_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [10:0] opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegWrite, Reg2Loc, ALUSrcA, fault;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic [31:0] cycle_cnt, instret_cnt;
    logic [15:0] strb;

    int checks = 0;
    int errors = 0;
    int exp_cyc = 0;
    int exp_ret = 0;
    bit exp_fault = 1'b0;

    always #5 CLK = ~CLK;

    multicycle_control #(.MEM_TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .fault(fault),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    assign strb = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                   RegWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    // Control strobes each state must show, straight from the state table.
    function automatic logic [15:0] exp_strb(int st, bit mr, bit r2l_dec);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, r2l, asa;
        logic [1:0] asb, aop, pcs;
        pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0; rw = 0; r2l = 0; asa = 0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            ST_FETCH:    begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
            ST_DECODE:   begin asb = 2'b11; r2l = r2l_dec; end
            ST_MEM_ADDR: begin asa = 1; asb = 2'b10; end
            ST_MEM_RD:   begin mrd = 1; iord = 1; end
            ST_WB_MEM:   begin rw = 1; m2r = 1; end
            ST_MEM_WR:   begin mwr = 1; iord = 1; r2l = 1; end
            ST_EXEC_R:   begin asa = 1; aop = 2'b10; end
            ST_WB_R:     rw = 1;
            ST_BRANCH_Z: begin asa = 1; aop = 2'b01; r2l = 1; pcwc = 1; pcs = 2'b01; end
            ST_JUMP:     begin pcw = 1; pcs = 2'b01; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, r2l, asa, asb, aop, pcs};
    endfunction

    function automatic logic [10:0] make_op(int cls);
        logic [10:0] rops [4];
        rops[0] = 11'b10001011000; rops[1] = 11'b11001011000;
        rops[2] = 11'b10001010000; rops[3] = 11'b10101010000;
        case (cls)
            C_RTYPE: return rops[$urandom_range(0, 3)];
            C_LDUR:  return 11'b11111000010;
            C_STUR:  return 11'b11111000000;
            C_CBZ:   return {8'b10110100, 3'($urandom)};
            default: return {6'b000101, 5'($urandom)};
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge: drive inputs, check this cycle, advance to the next negedge.
    task automatic step(int st, bit mr, logic [10:0] opc, bit r2l_dec);
        mem_ready = mr;
        opcode    = opc;
        #1;
        if (st == ST_HALT) exp_fault = 1'b1;
        chk("state", 32'(state), 32'(st));
        chk("strobes", 32'(strb), 32'(exp_strb(st, mr, r2l_dec)));
        chk("fault", 32'(fault), 32'(exp_fault));
        chk("cycle_cnt", cycle_cnt, PERF ? 32'(exp_cyc) : 32'd0);
        chk("instret_cnt", instret_cnt, PERF ? 32'(exp_ret) : 32'd0);
        if (st != ST_HALT) exp_cyc++;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        Reset_L   = 1'b0;
        mem_ready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_state", 32'(state), 32'(ST_FETCH));
            chk("rst_strobes", 32'(strb), 32'd0);
            chk("rst_fault", 32'(fault), 32'd0);
            chk("rst_cycle_cnt", cycle_cnt, 32'd0);
            chk("rst_instret_cnt", instret_cnt, 32'd0);
            if (k == 0) @(negedge CLK);
        end
        Reset_L   = 1'b1;
        exp_cyc   = 0;
        exp_ret   = 0;
        exp_fault = 1'b0;
    endtask

    task automatic fetch(int fw);
        for (int k = 0; k < fw; k++) step(ST_FETCH, 1'b0, 11'($urandom), 1'b0);
        step(ST_FETCH, 1'b1, 11'($urandom), 1'b0);
    endtask

    // Expected trace of one legal instruction: fw fetch waits, mw data-memory waits.
    task automatic run_instr(int cls, int fw, int mw);
        logic [10:0] opc;
        opc = make_op(cls);
        fetch(fw);
        step(ST_DECODE, 1'($urandom), opc, (cls == C_STUR) || (cls == C_CBZ));
        case (cls)
            C_RTYPE: begin
                step(ST_EXEC_R, 1'($urandom), opc, 1'b0);
                step(ST_WB_R, 1'($urandom), opc, 1'b0);
            end
            C_LDUR: begin
                step(ST_MEM_ADDR, 1'($urandom), opc, 1'b0);
                for (int k = 0; k < mw; k++) step(ST_MEM_RD, 1'b0, opc, 1'b0);
                step(ST_MEM_RD, 1'b1, opc, 1'b0);
                step(ST_WB_MEM, 1'($urandom), opc, 1'b0);
            end
            C_STUR: begin
                step(ST_MEM_ADDR, 1'($urandom), opc, 1'b0);
                for (int k = 0; k < mw; k++) step(ST_MEM_WR, 1'b0, opc, 1'b0);
                step(ST_MEM_WR, 1'b1, opc, 1'b0);
            end
            C_CBZ:   step(ST_BRANCH_Z, 1'($urandom), opc, 1'b0);
            default: step(ST_JUMP, 1'($urandom), opc, 1'b0);
        endcase
        exp_ret++;
    endtask

    task automatic halt_for(int n);
        for (int k = 0; k < n; k++) step(ST_HALT, 1'($urandom), 11'($urandom), 1'b0);
    endtask

    initial begin
        Reset_L   = 1'b0;
        mem_ready = 1'b0;
        opcode    = '0;
        @(negedge CLK);
        do_reset();

        // Directed: one of each class, then LDUR with a 3-cycle data wait.
        run_instr(C_RTYPE, 0, 0);
        run_instr(C_LDUR, 0, 3);
        run_instr(C_STUR, 0, 0);
        run_instr(C_CBZ, 0, 0);
        run_instr(C_B, 0, 0);
        run_instr(C_LDUR, 0, 0);

        // Random instruction mix with random memory latency.
        for (int n = 0; n < 40; n++)
            run_instr($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 5));

        // Ready arriving on the last allowed wait cycle still completes.
        run_instr(C_LDUR, TIMEOUT - 1, TIMEOUT - 1);
        run_instr(C_STUR, TIMEOUT - 1, TIMEOUT - 1);

        // Fetch timeout: exactly TIMEOUT wait cycles, then frozen in HALT.
        for (int k = 0; k < TIMEOUT; k++) step(ST_FETCH, 1'b0, 11'($urandom), 1'b0);
        halt_for(20);
        do_reset();

        // Illegal opcode.
        fetch(0);
        step(ST_DECODE, 1'b1, 11'h7FF, 1'b0);
        halt_for(20);
        do_reset();

        // Store timeout: the store does not retire.
        run_instr(C_RTYPE, 1, 0);
        fetch(0);
        step(ST_DECODE, 1'b0, 11'b11111000000, 1'b1);
        step(ST_MEM_ADDR, 1'b0, 11'b11111000000, 1'b0);
        for (int k = 0; k < TIMEOUT; k++) step(ST_MEM_WR, 1'b0, 11'b11111000000, 1'b0);
        halt_for(3);

        // Reset pulsed in the middle of a load wait, then normal fetch resumes.
        do_reset();
        run_instr(C_B, 0, 0);
        fetch(0);
        step(ST_DECODE, 1'b0, 11'b11111000010, 1'b0);
        step(ST_MEM_ADDR, 1'b0, 11'b11111000010, 1'b0);
        step(ST_MEM_RD, 1'b0, 11'b11111000010, 1'b0);
        step(ST_MEM_RD, 1'b0, 11'b11111000010, 1'b0);
        #2;
        do_reset();
        run_instr(C_RTYPE, 0, 0);
        run_instr(C_CBZ, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
